// File: rtl/aes_arbiter.sv
// Two-requester round-robin front end for one shared AES-128 core.
// One job is in flight at a time; a job is aborted with an error if the core stays busy too long.
module aes_arbiter #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid_i,
   output logic         req0_ready_o,
   input  logic [127:0] req0_key_i,
   input  logic [127:0] req0_data_i,
   input  logic         req1_valid_i,
   output logic         req1_ready_o,
   input  logic [127:0] req1_key_i,
   input  logic [127:0] req1_data_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic         rsp_id_o,
   output logic [127:0] rsp_data_o,
   output logic         rsp_err_o,
   output logic         core_load_o,
   output logic [127:0] core_key_o,
   output logic [127:0] core_data_o,
   input  logic         core_busy_i,
   input  logic [127:0] core_data_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, RESP} state_t;

   state_t        state;
   logic          last_grant;
   logic          grant;
   logic          accept;
   logic          job_id;
   logic [127:0]  job_key;
   logic [127:0]  job_data;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid_i && req1_valid_i) grant = ~last_grant;
      else                              grant = req1_valid_i;
   end

   assign req0_ready_o = rst_n && (state == IDLE) && !grant && req0_valid_i;
   assign req1_ready_o = rst_n && (state == IDLE) &&  grant && req1_valid_i;
   assign accept       = req0_ready_o | req1_ready_o;

   assign cnt_inc     = (cnt == T_MAX) ? cnt : cnt + 1'b1;
   assign rsp_id_o    = job_id;
   assign core_key_o  = job_key;
   assign core_data_o = job_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         cnt         <= '0;
         job_id      <= 1'b0;
         job_key     <= '0;
         job_data    <= '0;
         core_load_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         core_load_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  job_id      <= grant;
                  job_key     <= grant ? req1_key_i  : req0_key_i;
                  job_data    <= grant ? req1_data_i : req0_data_i;
                  core_load_o <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: state <= SETTLE;
            SETTLE: begin
               // busy is not trustworthy yet; just arm the timeout
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (!core_busy_i) begin
                  rsp_data_o  <= core_data_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == T_MAX) begin
                     rsp_data_o  <= '0;
                     rsp_err_o   <= 1'b1;
                     rsp_valid_o <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  last_grant  <= job_id;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_arbiter.sv
// Randomized bench for aes_arbiter: behavioural AES core model plus a job-level scoreboard.
module tb_aes_arbiter;
   localparam int TO = 10;
   localparam logic [127:0] STUB = 128'hc0ffee00_11223344_55667788_99aabbcc;

   typedef struct {
      logic [127:0] key;
      logic [127:0] data;
      int           lat;
      bit           stub;
   } job_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
   logic [127:0] req0_key = '0, req0_data = '0, req1_key = '0, req1_data = '0;
   logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, core_load, core_busy;
   logic [127:0] rsp_data, core_key, core_data, core_dout;

   always #5 clk = ~clk;

   aes_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_key_i(req0_key), .req0_data_i(req0_data),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_key_i(req1_key), .req1_data_i(req1_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .core_load_o(core_load), .core_key_o(core_key), .core_data_o(core_data),
      .core_busy_i(core_busy), .core_data_i(core_dout)
   );

   // ---------------- AES-128 reference ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] x, inv;
      for (int i = 0; i < 256; i++) begin
         x = 8'(i);
         inv = 8'h01;
         if (x == 8'h00) inv = 8'h00;
         else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
         sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0] w [44];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [31:0] tmp;
      logic [127:0] ct;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) s[c*4+rw] = t[((c+rw)%4)*4+rw];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
               s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // ---------------- core model: busy for 'lat' cycles after the load edge ----------------
   int cur_lat = 0;
   bit cur_stub = 0;
   int rem = 0;
   int n_loads = 0;
   logic [127:0] core_res = '0;

   always @(posedge clk) begin
      if (core_load) begin
         rem      <= cur_lat;
         core_res <= cur_stub ? STUB : aes128(core_key, core_data);
         n_loads  <= n_loads + 1;
      end else if (rem > 0) rem <= rem - 1;
   end
   assign core_busy = (rem != 0);
   assign core_dout = core_busy ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef : core_res;

   // ---------------- scoreboard ----------------
   int n_chk = 0, n_fail = 0;
   int cyc = 0, load_cyc = 0, rsp_due = 0, bp_left = 0;
   bit inflight = 0, known = 0, post_rst = 0, rnd_rdy = 0;
   logic last = 1'b1, cur_id = 1'b0, exp_err = 1'b0;
   logic [127:0] exp_key = '0, exp_dat = '0, exp_rsp = '0, last_data = '0;
   job_t q0 [$];
   job_t q1 [$];
   logic ids [$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic start_job(input job_t j, input logic id);
      int jend;
      cur_id   = id;
      exp_key  = j.key;
      exp_dat  = j.data;
      cur_lat  = j.lat;
      cur_stub = j.stub;
      load_cyc = cyc;
      // core done within the timeout window -> success, otherwise aborted at the window end
      jend     = (j.lat > TO) ? TO : ((j.lat < 1) ? 1 : j.lat);
      rsp_due  = load_cyc + 2 + jend;
      exp_err  = (j.lat > TO);
      exp_rsp  = exp_err ? 128'h0 : (j.stub ? STUB : aes128(j.key, j.data));
      inflight = 1;
      post_rst = 0;
   endtask

   task automatic step(input bit rst_val);
      bit v0, v1, g, r0, r1, rv, hs;
      job_t j;
      @(negedge clk);
      rst_n = rst_val;
      v0 = (q0.size() > 0);
      v1 = (q1.size() > 0);
      req0_valid = v0;
      req1_valid = v1;
      if (v0) begin req0_key = q0[0].key; req0_data = q0[0].data; end
      else    begin req0_key = {4{$urandom}}; req0_data = {4{$urandom}}; end
      if (v1) begin req1_key = q1[0].key; req1_data = q1[0].data; end
      else    begin req1_key = {4{$urandom}}; req1_data = {4{$urandom}}; end
      g  = (v0 && v1) ? !last : v1;
      r0 = rst_val && !inflight && !g && v0;
      r1 = rst_val && !inflight &&  g && v1;
      rv = inflight && (cyc >= rsp_due);
      rsp_ready = rnd_rdy ? 1'($urandom) : ((rv && bp_left > 0) ? 1'b0 : 1'b1);
      #1;
      if (known) begin
         chk("req0_ready", req0_ready, r0);
         chk("req1_ready", req1_ready, r1);
         chk("core_load", core_load, inflight && (cyc == load_cyc));
         chk("core_key", core_key, exp_key);
         chk("core_data", core_data, exp_dat);
         chk("rsp_valid", rsp_valid, rv);
         if (rv) begin
            chk("rsp_id", rsp_id, cur_id);
            chk("rsp_data", rsp_data, exp_rsp);
            chk("rsp_err", rsp_err, exp_err);
         end
         if (post_rst) begin
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", rsp_err, 0);
         end
      end
      hs = rst_val && rv && rsp_ready;
      if (hs) begin ids.push_back(rsp_id); last_data = rsp_data; end
      @(posedge clk);
      cyc++;
      if (!rst_val) begin
         inflight = 0; last = 1'b1; known = 1; post_rst = 1;
         exp_key = '0; exp_dat = '0;
      end else begin
         if (hs) begin inflight = 0; last = cur_id; end
         if (rv && !rsp_ready && bp_left > 0) bp_left--;
         if (r0) begin j = q0.pop_front(); start_job(j, 1'b0); end
         if (r1) begin j = q1.pop_front(); start_job(j, 1'b1); end
      end
   endtask

   task automatic run_idle();
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || inflight) && n < 3000) begin
         step(1'b1);
         n++;
      end
      chk("drain_timeout", n < 3000, 1);
   endtask

   function automatic job_t mk(input int lat, input bit stub);
      job_t j;
      j.key  = {$urandom, $urandom, $urandom, $urandom};
      j.data = {$urandom, $urandom, $urandom, $urandom};
      j.lat  = lat;
      j.stub = stub;
      return j;
   endfunction

   initial begin
      job_t j;
      int l0, n;
      build_sbox();
      for (int i = 0; i < 3; i++) step(1'b0);
      step(1'b1);

      // alternating service under constant contention
      ids.delete();
      for (int i = 0; i < 2; i++) begin
         q0.push_back(mk($urandom_range(0, 6), 0));
         q1.push_back(mk($urandom_range(0, 6), 0));
      end
      run_idle();
      chk("rr_count", ids.size(), 4);
      if (ids.size() == 4) begin
         chk("rr_id0", ids[0], 0);
         chk("rr_id1", ids[1], 1);
         chk("rr_id2", ids[2], 0);
         chk("rr_id3", ids[3], 1);
      end

      // FIPS-197 known answer
      l0 = n_loads;
      j.key = 128'h000102030405060708090a0b0c0d0e0f;
      j.data = 128'h00112233445566778899aabbccddeeff;
      j.lat = 4; j.stub = 0;
      q0.push_back(j);
      run_idle();
      chk("kat_data", last_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("kat_id", ids[$], 0);
      chk("kat_loads", n_loads - l0, 1);

      // response backpressure with a competing request pending
      bp_left = 20;
      q0.push_back(mk(3, 0));
      q1.push_back(mk(2, 0));
      run_idle();
      chk("bp_drained", bp_left, 0);

      // stuck core times out, then a normal job
      q0.push_back(mk(1000, 1));
      q0.push_back(mk(2, 0));
      run_idle();

      // busy drop on the last allowed cycle, one past it, and immediately
      q1.push_back(mk(TO, 1));
      q1.push_back(mk(TO + 1, 1));
      q1.push_back(mk(0, 1));
      run_idle();

      // reset while waiting on the core
      q0.push_back(mk(8, 0));
      n = 0;
      while (!(inflight && cyc == load_cyc + 3) && n < 50) begin step(1'b1); n++; end
      chk("reach_wait", n < 50, 1);
      step(1'b0);
      q1.push_back(mk(3, 0));
      run_idle();
      chk("post_rst_id", ids[$], 1);

      // random traffic
      rnd_rdy = 1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) != 0) q0.push_back(mk($urandom_range(0, TO + 3), ($urandom % 4) == 0));
         if ($urandom_range(0, 2) != 0) q1.push_back(mk($urandom_range(0, TO + 3), ($urandom % 4) == 0));
         for (int k = 0; k < $urandom_range(1, 12); k++) step(1'b1);
      end
      run_idle();
      rnd_rdy = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
